// File: rtl/irq_controller_if.sv
// Port-bus and interrupt signals between the core, the event sources and irq_controller.
interface irq_controller_if;
    logic [7:0]  irq_req;
    logic [15:0] port_a;
    logic        port_w;
    logic        port_r;
    logic [7:0]  port_o;
    logic [7:0]  port_i;
    logic        port_hit;
    logic        irq;
    logic [7:0]  irq_in;
    logic        in_service;

    modport master (
        output irq_req, port_a, port_w, port_r, port_o,
        input  port_i, port_hit, irq, irq_in, in_service
    );

    modport slave (
        input  irq_req, port_a, port_w, port_r, port_o,
        output port_i, port_hit, irq, irq_in, in_service
    );
endinterface

// File: rtl/irq_controller.sv
// 8-line interrupt controller: latches events, masks them, grants one at a time
// on a toggle-style irq line and holds further grants until EOI.
module irq_controller #(
    parameter logic [7:0]  VECTOR_BASE = 8'd8,
    parameter logic [15:0] PORT_CMD    = 16'h0020,
    parameter logic [15:0] PORT_MASK   = 16'h00A0,
    parameter logic [7:0]  MASK_RESET  = 8'hFF
) (
    input logic              clock,
    input logic              reset,
    irq_controller_if.slave  bus
);
    localparam int unsigned NLINES = 8;
    localparam int unsigned IDX_W  = 3;

    logic [NLINES-1:0] irr_q, irr_d;
    logic [NLINES-1:0] imr_q, imr_d;
    logic              in_service_q, in_service_d;
    logic [IDX_W-1:0]  active_q, active_d;
    logic              irq_q, irq_d;
    logic [7:0]        irq_in_q, irq_in_d;
    logic [7:0]        port_i_q, port_i_d;
    logic              port_hit_q, port_hit_d;

    logic [NLINES-1:0] pending;
    logic [NLINES-1:0] grant_mask;
    logic [IDX_W-1:0]  grant_idx;
    logic              grant;
    logic              cmd_wr;
    logic              eoi;

    // Priority pick (line 0 highest), EOI decode and next-state for every register.
    always_comb begin
        pending      = irr_q & ~imr_q;
        grant        = !in_service_q && (pending != '0);
        grant_idx    = '0;
        grant_mask   = '0;
        irr_d        = irr_q;
        imr_d        = imr_q;
        in_service_d = in_service_q;
        active_d     = active_q;
        irq_d        = irq_q;
        irq_in_d     = irq_in_q;
        port_i_d     = port_i_q;
        port_hit_d   = 1'b0;

        for (int i = NLINES - 1; i >= 0; i--) begin
            if (pending[i]) begin
                grant_idx = IDX_W'(i);
            end
        end

        cmd_wr = bus.port_w && (bus.port_a == PORT_CMD);
        eoi    = cmd_wr && ((bus.port_o == 8'h20) ||
                 ((bus.port_o[7:3] == 5'b01100) && (bus.port_o[2:0] == active_q)));

        if (grant) begin
            grant_mask[grant_idx] = 1'b1;
            in_service_d          = 1'b1;
            active_d              = grant_idx;
            irq_d                 = ~irq_q;
            irq_in_d              = VECTOR_BASE + 8'(grant_idx);
        end else if (eoi) begin
            in_service_d = 1'b0;
        end

        // A new event on the line being granted survives the clear.
        irr_d = (irr_q & ~grant_mask) | bus.irq_req;

        if (bus.port_w && (bus.port_a == PORT_MASK)) begin
            imr_d = bus.port_o;
        end

        if (bus.port_r) begin
            if (bus.port_a == PORT_CMD) begin
                port_i_d   = irr_q;
                port_hit_d = 1'b1;
            end else if (bus.port_a == PORT_MASK) begin
                port_i_d   = imr_q;
                port_hit_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            irr_q        <= '0;
            imr_q        <= MASK_RESET;
            in_service_q <= 1'b0;
            active_q     <= '0;
            irq_q        <= 1'b0;
            irq_in_q     <= VECTOR_BASE;
            port_i_q     <= '0;
            port_hit_q   <= 1'b0;
        end else begin
            irr_q        <= irr_d;
            imr_q        <= imr_d;
            in_service_q <= in_service_d;
            active_q     <= active_d;
            irq_q        <= irq_d;
            irq_in_q     <= irq_in_d;
            port_i_q     <= port_i_d;
            port_hit_q   <= port_hit_d;
        end
    end

    assign bus.irq        = irq_q;
    assign bus.irq_in     = irq_in_q;
    assign bus.in_service = in_service_q;
    assign bus.port_i     = port_i_q;
    assign bus.port_hit   = port_hit_q;
endmodule
